// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream stage.
package fifo_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int SKID_DEPTH = 3;

  typedef enum logic {
    BST_IDLE   = 1'b0,
    BST_ACTIVE = 1'b1
  } burst_st_e;
endpackage

// File: rtl/stream_skid_buf.sv
// Three-entry circular skid buffer; head entry is always visible on head_data.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [1:0]       head;
  logic [1:0]       tail;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Storage is cleared on reset so the head reads zero until the first capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      head <= 2'd0;
      tail <= 2'd0;
      occ  <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: issues reads from flags, absorbs the one-cycle read
// latency in a skid buffer and presents bursts on a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  err_underflow,
  output logic                  idle
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  logic             inflight;
  logic [1:0]       occ;
  logic [2:0]       pending;
  logic             pop;
  burst_st_e        state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  // Issue only from registered occupancy so m_ready never reaches fifo_rd_en;
  // the in-flight word is counted so it always has a slot waiting.
  assign pending    = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = enable & ~fifo_empty & (pending < 3'(SKID_DEPTH)) & ~rst;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid & (beat_cnt == LAST_CNT);
  assign idle    = (occ == 2'd0) & ~inflight & fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end

  stream_skid_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_underflow <= 1'b0;
    else if (fifo_underflow) err_underflow <= 1'b1;
  end

  // Burst tracking: counter holds across empty gaps so a burst resumes mid-way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BST_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      BST_IDLE: begin
        if (pop && (BURST_LEN > 1)) begin
          state_nxt    = BST_ACTIVE;
          beat_cnt_nxt = CNT_W'(1);
        end
      end
      BST_ACTIVE: begin
        if (pop) begin
          if (beat_cnt == LAST_CNT) begin
            state_nxt    = BST_IDLE;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt    = BST_IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural one-cycle-latency FIFO.
module tb_fifo_rd_stream;

  localparam int DW = 16;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          err_underflow;
  logic          idle;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fmem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic [DW-1:0] exp_q [$];
  int beat_idx  = 0;
  int popped    = 0;
  int rd_pulses = 0;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .err_underflow  (err_underflow),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO model: registered read data, flushed by the shared reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_data_out <= fmem[rd_ptr % 1024];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Beat monitor: sampled mid-cycle, a beat here is popped on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      beat_idx = 0;
    end else begin
      if (fifo_rd_en) rd_pulses++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", {16'h0, m_data}, 32'hFFFF_FFFF);
        end else begin
          chk("beat_data", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
        end
        chk("beat_last", {31'h0, m_last}, {31'h0, ((beat_idx % BL) == BL - 1)});
        beat_idx++;
        popped++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [DW-1:0] v);
    fmem[wr_ptr % 1024] = v;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(v);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    m_ready        = 1'b0;
    fifo_underflow = 1'b0;
    tick(3);

    // Reset state
    chk("rst_rd_en",   {31'h0, fifo_rd_en},    0);
    chk("rst_valid",   {31'h0, m_valid},       0);
    chk("rst_data",    {16'h0, m_data},        0);
    chk("rst_last",    {31'h0, m_last},        0);
    chk("rst_err",     {31'h0, err_underflow}, 0);
    chk("rst_idle",    {31'h0, idle},          1);

    rst    = 1'b0;
    enable = 1'b1;
    tick(3);
    chk("empty_rd_en", {31'h0, fifo_rd_en}, 0);
    chk("empty_idle",  {31'h0, idle},       1);
    chk("empty_valid", {31'h0, m_valid},    0);

    // Eight words at full rate
    m_ready = 1'b1;
    popped  = 0;
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
    #1;
    chk("lat_rd_en", {31'h0, fifo_rd_en}, 1);
    chk("lat_v0",    {31'h0, m_valid},    0);
    tick(1);
    chk("lat_v1",    {31'h0, m_valid},    0);
    tick(1);
    chk("lat_v2",    {31'h0, m_valid},    1);
    chk("lat_data",  {16'h0, m_data},     32'h1);
    tick(8);
    chk("burst8_cnt",   popped,              8);
    chk("burst8_valid", {31'h0, m_valid},    0);
    chk("burst8_idle",  {31'h0, idle},       1);

    // Backpressure: only three reads may be issued
    m_ready   = 1'b0;
    popped    = 0;
    rd_pulses = 0;
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
    tick(2);
    for (int i = 0; i < 8; i++) begin
      chk("bp_valid", {31'h0, m_valid}, 1);
      chk("bp_data",  {16'h0, m_data},  32'h1);
      tick(1);
    end
    chk("bp_pulses", rd_pulses,        3);
    chk("bp_last",   {31'h0, m_last},  0);
    m_ready = 1'b1;
    wait_drain(40);
    tick(3);
    chk("bp_popped", popped,          8);
    chk("bp_idle",   {31'h0, idle},   1);

    // Random backpressure over 200 words
    popped = 0;
    for (int i = 0; i < 200; i++) fifo_write(DW'(16'h0100 + i));
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        m_ready = 1'($urandom_range(0, 1));
        tick(1);
        n++;
      end
    end
    chk("rand_left",   exp_q.size(), 0);
    chk("rand_popped", popped,       200);
    chk("rand_align",  beat_idx % BL, 0);
    m_ready = 1'b1;
    tick(3);
    chk("rand_idle",   {31'h0, idle}, 1);

    // Sticky underflow
    chk("err_before", {31'h0, err_underflow}, 0);
    fifo_underflow = 1'b1;
    tick(1);
    fifo_underflow = 1'b0;
    chk("err_set",    {31'h0, err_underflow}, 1);
    tick(5);
    chk("err_sticky", {31'h0, err_underflow}, 1);

    // Reset in the middle of a burst
    m_ready = 1'b0;
    fifo_write(16'h00A1);
    fifo_write(16'h00A2);
    fifo_write(16'h00A3);
    fifo_write(16'h00A4);
    tick(5);
    m_ready = 1'b1;
    tick(2);
    m_ready = 1'b0;
    tick(1);
    chk("mid_valid", {31'h0, m_valid}, 1);
    chk("mid_data",  {16'h0, m_data},  32'h00A3);
    chk("mid_last",  {31'h0, m_last},  0);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, m_valid},       0);
    chk("arst_data",  {16'h0, m_data},        0);
    chk("arst_rd_en", {31'h0, fifo_rd_en},    0);
    chk("arst_err",   {31'h0, err_underflow}, 0);
    exp_q.delete();
    tick(2);
    rst     = 1'b0;
    m_ready = 1'b1;
    popped  = 0;
    tick(1);
    chk("post_idle", {31'h0, idle}, 1);
    fifo_write(16'h00B1);
    fifo_write(16'h00B2);
    fifo_write(16'h00B3);
    fifo_write(16'h00B4);
    tick(2);
    chk("post_data", {16'h0, m_data}, 32'h00B1);
    chk("post_last", {31'h0, m_last}, 0);
    wait_drain(20);
    tick(2);
    chk("post_popped", popped,   4);
    chk("post_align",  beat_idx, 4);
    chk("post_idle2",  {31'h0, idle}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
